// File: rtl/mem_arbiter.sv
// Two-core RAM port arbiter: round-robin between cores, data ahead of fetch within a core.
// Define ARB_TIMEOUT_EN to add a GRANT watchdog that flags err and yields to the other core.
module mem_arbiter #(
   parameter int ADDR_W = 32
`ifdef ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [1:0]            iREN,
   input  logic [1:0]            dREN,
   input  logic [1:0]            dWEN,
   input  logic [2*ADDR_W-1:0]   iaddr,
   input  logic [2*ADDR_W-1:0]   daddr,
   input  logic [2*ADDR_W-1:0]   dstore,
   output logic [1:0]            ihit,
   output logic [1:0]            dhit,
   output logic [ADDR_W-1:0]     load,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [ADDR_W-1:0]     ramaddr,
   output logic [ADDR_W-1:0]     ramstore,
   input  logic [ADDR_W-1:0]     ramload,
   input  logic [1:0]            ramstate,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, GRANT, HIT} state_t;
   typedef enum logic [1:0] {K_IFETCH, K_DREAD, K_DWRITE} kind_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   state_t              state_q;
   kind_t               kind_q;
   logic                core_q;
   logic                rr_last_q;
   logic                err_q;
   logic [1:0]          ihit_q;
   logic [1:0]          dhit_q;
   logic [ADDR_W-1:0]   load_q;
   logic                ren_q;
   logic                wen_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   store_q;
`ifdef ARB_TIMEOUT_EN
   logic [7:0]          tmo_q;
`endif

   logic [1:0]          elig;
   logic                pick_core;
   kind_t               pick_kind;
   logic [ADDR_W-1:0]   pick_addr;
   logic [ADDR_W-1:0]   pick_store;
   logic                req_held;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      elig       = iREN | dREN | dWEN;
      pick_core  = (elig == 2'b11) ? ~rr_last_q : elig[1];
      pick_kind  = K_IFETCH;
      if (dWEN[pick_core])
         pick_kind = K_DWRITE;
      else if (dREN[pick_core])
         pick_kind = K_DREAD;
      pick_store = pick_core ? dstore[2*ADDR_W-1:ADDR_W] : dstore[ADDR_W-1:0];
      if (pick_kind == K_IFETCH)
         pick_addr = pick_core ? iaddr[2*ADDR_W-1:ADDR_W] : iaddr[ADDR_W-1:0];
      else
         pick_addr = pick_core ? daddr[2*ADDR_W-1:ADDR_W] : daddr[ADDR_W-1:0];

      // The request bit that won the grant; its fall means the requester abandoned it.
      req_held = 1'b0;
      case (kind_q)
         K_DWRITE: req_held = dWEN[core_q];
         K_DREAD:  req_held = dREN[core_q];
         default:  req_held = iREN[core_q];
      endcase
   end

   // NOTE: all state and registered outputs live here and use non-blocking assignments only.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         kind_q    <= K_IFETCH;
         core_q    <= 1'b0;
         rr_last_q <= 1'b1;
         err_q     <= 1'b0;
         ihit_q    <= '0;
         dhit_q    <= '0;
         load_q    <= '0;
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         store_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         ihit_q <= '0;
         dhit_q <= '0;
         case (state_q)
            IDLE: begin
               if (|elig) begin
                  core_q  <= pick_core;
                  kind_q  <= pick_kind;
                  addr_q  <= pick_addr;
                  store_q <= pick_store;
                  ren_q   <= (pick_kind != K_DWRITE);
                  wen_q   <= (pick_kind == K_DWRITE);
`ifdef ARB_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!req_held) begin
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (ramstate == RS_ERROR) begin
                  err_q   <= 1'b1;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (ramstate == RS_ACCESS) begin
                  if (kind_q != K_DWRITE)
                     load_q <= ramload;
                  if (kind_q == K_IFETCH)
                     ihit_q <= core_q ? 2'b10 : 2'b01;
                  else
                     dhit_q <= core_q ? 2'b10 : 2'b01;
                  rr_last_q <= core_q;
                  ren_q     <= 1'b0;
                  wen_q     <= 1'b0;
                  state_q   <= HIT;
`ifdef ARB_TIMEOUT_EN
               end else if (tmo_q == 8'(TIMEOUT_CYCLES - 1)) begin
                  // Hand the next turn to the other core so a stuck requester cannot starve it.
                  err_q     <= 1'b1;
                  rr_last_q <= core_q;
                  ren_q     <= 1'b0;
                  wen_q     <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
`endif
               end
            end
            HIT:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ihit     = ihit_q;
   assign dhit     = dhit_q;
   assign load     = load_q;
   assign ramREN   = ren_q;
   assign ramWEN   = wen_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences for
// reset/watchdog corners, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

   localparam int W   = 32;
   localparam int TMO = 4;
   localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

   logic              CLK = 1'b0;
   logic              nRST;
   logic [1:0]        iREN, dREN, dWEN;
   logic [2*W-1:0]    iaddr, daddr, dstore;
   logic [1:0]        ihit, dhit;
   logic [W-1:0]      load;
   logic              ramREN, ramWEN;
   logic [W-1:0]      ramaddr, ramstore, ramload;
   logic [1:0]        ramstate;
   logic              err;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .ADDR_W(W)
`ifdef ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .ihit(ihit), .dhit(dhit), .load(load),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      logic [1:0]  iren, dren, dwen, rs;
      logic [31:0] rl;
      logic [1:0]  ihit, dhit;
      logic        ren, wen;
      logic [31:0] addr, store, load;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [1:0] ir, dr, dw, rs, input logic [31:0] rl,
                      input logic [1:0] ih, dh, input logic rn, wn,
                      input logic [31:0] ad, st, ld, input logic er);
      vec_t v;
      v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs; v.rl = rl;
      v.ihit = ih; v.dhit = dh; v.ren = rn; v.wen = wn;
      v.addr = ad; v.store = st; v.load = ld; v.err = er;
      tbl.push_back(v);
   endtask

   task automatic fixed_bus();
      iaddr  = {32'h0000_1100, 32'h0000_0100};
      daddr  = {32'h0000_0200, 32'h0000_0300};
      dstore = {32'h1234_5678, 32'hAAAA_5555};
   endtask

   // Random-phase reference model (transaction level).
   logic        m_win, m_rest, m_err, m_rr, m_core;
   int          m_kind, m_wait;
   logic [31:0] m_addr, m_store, m_load;
   logic [1:0]  m_ihit, m_dhit;
   logic [1:0]  p_i, p_dr, p_dw;

   task automatic model_cycle();
      logic [1:0] wants;
      m_ihit = '0;
      m_dhit = '0;
      if (m_win) begin
         if (ramstate == RS_ACCESS) begin
            if (m_kind == 0) m_ihit[m_core] = 1'b1;
            else             m_dhit[m_core] = 1'b1;
            if (m_kind != 2) m_load = ramload;
            m_rr   = m_core;
            m_win  = 1'b0;
            m_rest = 1'b1;
         end else if (ramstate == RS_ERROR) begin
            m_err = 1'b1;
            m_win = 1'b0;
         end else begin
`ifdef ARB_TIMEOUT_EN
            m_wait++;
            if (m_wait == TMO) begin
               m_err = 1'b1;
               m_rr  = m_core;
               m_win = 1'b0;
            end
`endif
         end
      end else if (m_rest) begin
         m_rest = 1'b0;
      end else begin
         wants = iREN | dREN | dWEN;
         // First core after the last winner, in round-robin order, that wants service.
         for (int k = 2; k >= 1; k--) begin
            int c;
            c = (int'(m_rr) + k) % 2;
            if (wants[c]) m_core = c[0];
         end
         if (wants != 2'b00) begin
            m_kind  = dWEN[m_core] ? 2 : (dREN[m_core] ? 1 : 0);
            m_addr  = (m_kind == 0) ? iaddr[int'(m_core)*W +: W] : daddr[int'(m_core)*W +: W];
            m_store = dstore[int'(m_core)*W +: W];
            m_win   = 1'b1;
            m_wait  = 0;
         end
      end
   endtask

   initial begin
      nRST = 1'b0;
      iREN = '0; dREN = '0; dWEN = '0;
      ramstate = RS_FREE; ramload = '0;
      fixed_bus();
      #12;
      check("reset ihit", ihit, 2'b00);
      check("reset dhit", dhit, 2'b00);
      check("reset ramREN", ramREN, 1'b0);
      check("reset ramWEN", ramWEN, 1'b0);
      check("reset err", err, 1'b0);
      check("reset ramaddr", ramaddr, 32'h0);
      check("reset ramstore", ramstore, 32'h0);
      check("reset load", load, 32'h0);
      @(negedge CLK) nRST = 1'b1;

      // iren dren dwen rs ramload | ihit dhit ren wen addr store load err
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'hDEADBEEF, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h0, 0);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'hDEADBEEF, 2'b01, 2'b00, 0, 0, 32'h100, 0, 32'hDEADBEEF, 0);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h0BADF00D, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'hDEADBEEF, 0);
      for (int i = 0; i < 4; i++)
         add(2'b00, 2'b00, 2'b10, RS_BUSY, 32'h0BADF00D, 2'b00, 2'b00, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0);
      add(2'b00, 2'b00, 2'b10, RS_ACCESS, 32'h0BADF00D, 2'b00, 2'b10, 0, 0, 32'h200, 0, 32'hDEADBEEF, 0);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h0BADF00D, 2'b00, 2'b00, 0, 0, 32'h200, 0, 32'hDEADBEEF, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h11111111, 2'b00, 2'b00, 1, 0, 32'h100,  0, 32'hDEADBEEF, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h11111111, 2'b01, 2'b00, 0, 0, 32'h100,  0, 32'h11111111, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h22222222, 2'b00, 2'b00, 0, 0, 32'h100,  0, 32'h11111111, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h22222222, 2'b00, 2'b00, 1, 0, 32'h1100, 0, 32'h11111111, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h22222222, 2'b10, 2'b00, 0, 0, 32'h1100, 0, 32'h22222222, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h33333333, 2'b00, 2'b00, 0, 0, 32'h1100, 0, 32'h22222222, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h33333333, 2'b00, 2'b00, 1, 0, 32'h100,  0, 32'h22222222, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h33333333, 2'b01, 2'b00, 0, 0, 32'h100,  0, 32'h33333333, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h44444444, 2'b00, 2'b00, 0, 0, 32'h100,  0, 32'h33333333, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h44444444, 2'b00, 2'b00, 1, 0, 32'h1100, 0, 32'h33333333, 0);
      add(2'b11, 2'b00, 2'b00, RS_ACCESS, 32'h44444444, 2'b10, 2'b00, 0, 0, 32'h1100, 0, 32'h44444444, 0);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h44444444, 2'b00, 2'b00, 0, 0, 32'h1100, 0, 32'h44444444, 0);
      add(2'b01, 2'b01, 2'b00, RS_ACCESS, 32'h55555555, 2'b00, 2'b00, 1, 0, 32'h300, 0, 32'h44444444, 0);
      add(2'b01, 2'b01, 2'b00, RS_ACCESS, 32'h55555555, 2'b00, 2'b01, 0, 0, 32'h300, 0, 32'h55555555, 0);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'h66666666, 2'b00, 2'b00, 0, 0, 32'h300, 0, 32'h55555555, 0);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'h66666666, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h55555555, 0);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'h66666666, 2'b01, 2'b00, 0, 0, 32'h100, 0, 32'h66666666, 0);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h66666666, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'h66666666, 0);
      add(2'b01, 2'b00, 2'b00, RS_ERROR,  32'h77777777, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h66666666, 0);
      add(2'b01, 2'b00, 2'b00, RS_ERROR,  32'h77777777, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'h66666666, 1);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'h88888888, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h66666666, 1);
      add(2'b01, 2'b00, 2'b00, RS_ACCESS, 32'h88888888, 2'b01, 2'b00, 0, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h88888888, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b01, 2'b00, 2'b00, RS_BUSY,   32'h99999999, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b01, 2'b00, 2'b00, RS_BUSY,   32'h99999999, 2'b00, 2'b00, 1, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b00, 2'b00, 2'b00, RS_BUSY,   32'h99999999, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h99999999, 2'b00, 2'b00, 0, 0, 32'h100, 0, 32'h88888888, 1);
      add(2'b00, 2'b10, 2'b00, RS_ACCESS, 32'hAAAAAAAA, 2'b00, 2'b00, 1, 0, 32'h200, 0, 32'h88888888, 1);
      add(2'b00, 2'b10, 2'b00, RS_ACCESS, 32'hAAAAAAAA, 2'b00, 2'b10, 0, 0, 32'h200, 0, 32'hAAAAAAAA, 1);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'hAAAAAAAA, 2'b00, 2'b00, 0, 0, 32'h200, 0, 32'hAAAAAAAA, 1);
      add(2'b00, 2'b01, 2'b01, RS_ACCESS, 32'h0BADF00D, 2'b00, 2'b00, 0, 1, 32'h300, 32'hAAAA5555, 32'hAAAAAAAA, 1);
      add(2'b00, 2'b01, 2'b01, RS_ACCESS, 32'h0BADF00D, 2'b00, 2'b01, 0, 0, 32'h300, 0, 32'hAAAAAAAA, 1);
      add(2'b00, 2'b00, 2'b00, RS_FREE,   32'h0BADF00D, 2'b00, 2'b00, 0, 0, 32'h300, 0, 32'hAAAAAAAA, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
         ramstate = tbl[i].rs; ramload = tbl[i].rl;
         step();
         check($sformatf("row%0d ihit", i), ihit, tbl[i].ihit);
         check($sformatf("row%0d dhit", i), dhit, tbl[i].dhit);
         check($sformatf("row%0d ramREN", i), ramREN, tbl[i].ren);
         check($sformatf("row%0d ramWEN", i), ramWEN, tbl[i].wen);
         check($sformatf("row%0d ramaddr", i), ramaddr, tbl[i].addr);
         check($sformatf("row%0d load", i), load, tbl[i].load);
         check($sformatf("row%0d err", i), err, tbl[i].err);
         if (tbl[i].wen) check($sformatf("row%0d ramstore", i), ramstore, tbl[i].store);
      end

`ifdef ARB_TIMEOUT_EN
      // Watchdog: core0 stuck BUSY for TMO grant cycles, then core1 must be granted.
      @(negedge CLK) nRST = 1'b0;
      @(negedge CLK) nRST = 1'b1;
      iREN = 2'b11; ramstate = RS_BUSY;
      step();
      check("tmo grant core0", ramaddr, 32'h100);
      for (int i = 1; i < TMO; i++) begin
         step();
         check("tmo still granted", ramREN, 1'b1);
      end
      step();
      check("tmo enables drop", ramREN, 1'b0);
      check("tmo err set", err, 1'b1);
      check("tmo no hit", ihit, 2'b00);
      step();
      check("tmo core1 granted ren", ramREN, 1'b1);
      check("tmo core1 granted addr", ramaddr, 32'h1100);
      ramstate = RS_ACCESS;
      step();
      check("tmo core1 hit", ihit, 2'b10);
      iREN = 2'b00;
      step();
`endif

      // Reset in the middle of a grant: outputs clear at once and no hit follows.
      iREN = 2'b10; ramstate = RS_BUSY;
      step();
      check("midreset pre ren", ramREN, 1'b1);
      #2 nRST = 1'b0;
      #1;
      check("midreset ren", ramREN, 1'b0);
      check("midreset addr", ramaddr, 32'h0);
      check("midreset err", err, 1'b0);
      @(negedge CLK);
      iREN = 2'b00; ramstate = RS_ACCESS;
      nRST = 1'b1;
      step();
      check("postreset ihit", ihit, 2'b00);
      check("postreset ren", ramREN, 1'b0);

      // Randomized traffic: requesters hold until the model-predicted hit.
      m_win = 0; m_rest = 0; m_err = 0; m_rr = 1'b1; m_core = 1'b0;
      m_kind = 0; m_wait = 0; m_addr = '0; m_store = '0; m_load = '0;
      p_i = '0; p_dr = '0; p_dw = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         iREN = p_i; dREN = p_dr; dWEN = p_dw;
         r = $urandom_range(0, 99);
         ramstate = (r < 3) ? RS_ERROR : (r < 50) ? RS_ACCESS : (r < 80) ? RS_BUSY : RS_FREE;
         ramload = $urandom;
         model_cycle();
         step();
         check("rnd ihit", ihit, m_ihit);
         check("rnd dhit", dhit, m_dhit);
         check("rnd ramREN", ramREN, m_win && m_kind != 2);
         check("rnd ramWEN", ramWEN, m_win && m_kind == 2);
         check("rnd ramaddr", ramaddr, m_addr);
         check("rnd load", load, m_load);
         check("rnd err", err, m_err);
         if (m_win && m_kind == 2) check("rnd ramstore", ramstore, m_store);
         for (int c = 0; c < 2; c++) begin
            if (m_ihit[c]) p_i[c] = 1'b0;
            if (m_dhit[c]) begin p_dr[c] = 1'b0; p_dw[c] = 1'b0; end
            if (!(p_i[c] | p_dr[c] | p_dw[c]) && $urandom_range(0, 2) == 0) begin
               int k;
               k = $urandom_range(0, 5);
               p_i[c]  = (k == 0 || k == 4 || k == 5);
               p_dr[c] = (k == 1 || k == 3 || k == 4);
               p_dw[c] = (k == 2 || k == 3 || k == 5);
               iaddr[c*W +: W]  = $urandom;
               daddr[c*W +: W]  = $urandom;
               dstore[c*W +: W] = $urandom;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one RAM port between two cores; each core presents an instruction-fetch and a data request.
- Registered arbitration: round-robin between cores; data over instruction within a core.
- Drives RAM enables/address/store and returns one-cycle hit pulses plus registered load data.
- Sits between the per-core request units/caches and the system RAM.

Parameters:
- ADDR_W, 32, address and data width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with the optional feature; fits 8 bits).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  2  per-core instruction read request.
- dREN  in  2  per-core data read request.
- dWEN  in  2  per-core data write request.
- iaddr  in  2*ADDR_W  per-core fetch address; core c at [c*ADDR_W +: ADDR_W].
- daddr  in  2*ADDR_W  per-core data address.
- dstore  in  2*ADDR_W  per-core store data.
- ihit  out  2  one-hot, one-cycle fetch-complete pulse.
- dhit  out  2  one-hot, one-cycle data-complete pulse.
- load  out  ADDR_W  registered RAM read data, valid while a hit is high.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

Behaviour:
- One clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state IDLE; ihit, dhit, ramREN, ramWEN, err all 0; ramaddr, ramstore, load all 0; rr_last=1, so core 0 wins the first contention.
- FSM states: IDLE, GRANT, HIT.
- IDLE:
  - A core is eligible if iREN|dREN|dWEN is set.
  - If both cores are eligible, pick core != rr_last; if one, pick it; if none, stay in IDLE.
  - Within the chosen core, priority is dWEN > dREN > iREN. dWEN and dREN together are treated as a write.
  - Register grant (core, kind, address, store data), then go to GRANT.
  - RAM enables are 0 in IDLE.
- GRANT:
  - Drive ramaddr and ramstore from the registered grant.
  - Drive ramWEN for a write, otherwise ramREN.
  - Grant is held across ramstate FREE/BUSY.
  - ramstate==ACCESS: latch ramload into load (reads only), set rr_last=granted core, go to HIT.
  - ramstate==ERROR: set err=1, drop enables, go to IDLE with no hit.
  - Abort: if the granted request bit deasserts (e.g. a halted core drops iREN), go to IDLE next cycle with no hit and no rr_last update.
- HIT:
  - Exactly one of ihit/dhit is high for one cycle, at the granted core's bit.
  - RAM enables are 0.
  - Unconditionally go to IDLE.
- Latency: request sampled in IDLE at cycle t; enables active at t+1; ACCESS seen at t+k (k>=1); hit at t+k+1. Minimum is 2 cycles, and there is at least one idle cycle between back-to-back grants.
- Requesters hold request, address and data stable until the hit. Arbiter input changes during GRANT other than the abort bit are ignored.
- err clears only on reset.
- Reset mid-GRANT: everything returns to reset values immediately and no hit is issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to GRANT and increments each GRANT cycle without ACCESS. When it reaches TIMEOUT_CYCLES, set err=1, go to IDLE with no hit, and set rr_last=granted core, so a stuck requester cannot starve the other.
- Undefined: no counter; GRANT waits indefinitely.

Test Plan:
- Reset, then core0 iREN=1, iaddr=0x100, ramstate=ACCESS on the first grant cycle, ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x100 for one cycle; ihit[0]=1 and load=0xDEADBEEF two cycles after the request.
- Core1 dWEN=1, daddr=0x200, dstore=0x12345678; ramstate BUSY 3 cycles then ACCESS -> ramWEN=1 for 4 cycles, ramstore=0x12345678, then dhit[1] pulse; ihit stays 0.
- Both cores continuously assert iREN with ACCESS every grant -> hit order is core0, core1, core0, core1.
- Core0 iREN and dREN together -> data access served first (dhit[0]), then the fetch (ihit[0]).
- Core0 granted, ramstate=ERROR -> err=1 sticky, no hit, returns to IDLE; a new request is served normally with err still 1.
- Core0 drops iREN mid-GRANT -> enables fall, no ihit[0]; with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, ramstate stuck BUSY -> err=1 after 4 GRANT cycles, and core1's pending request is granted next.
